// File: rtl/ahb_ext_ram_pkg.sv
// ============================================================================
// Module      : ahb_ext_ram_pkg
// Description : Shared types and AHB transfer-type constants for ahb_ext_ram.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ahb_ext_ram_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WAIT = 3'd1,
      LAST = 3'd2,
      ERR1 = 3'd3,
      ERR2 = 3'd4
   } extram_state_t;

   localparam logic [1:0] c_htrans_idle   = 2'b00;
   localparam logic [1:0] c_htrans_busy   = 2'b01;
   localparam logic [1:0] c_htrans_nonseq = 2'b10;
   localparam logic [1:0] c_htrans_seq    = 2'b11;

   // Only NONSEQ and SEQ carry a real transfer.
   function automatic logic htrans_active(input logic [1:0] trans);
      case (trans)
         c_htrans_nonseq, c_htrans_seq: htrans_active = 1'b1;
         c_htrans_idle, c_htrans_busy:  htrans_active = 1'b0;
         default:                       htrans_active = 1'b0;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/extram_array.sv
// ============================================================================
// Module      : extram_array
// Description : Synchronous RAM, byte write enables, registered read-first port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module extram_array #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4096
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [WIDTH/8-1:0]       i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_re,
   input  logic [$clog2(DEPTH)-1:0] i_raddr,
   output logic [WIDTH-1:0]         o_rdata
);

   localparam int c_nb = WIDTH / 8;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   always_ff @(posedge clk) begin
      for (int b = 0; b < c_nb; b++) begin
         if (i_we[b]) begin
            r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
         end
      end
   end

   // Output register is cleared by reset; the storage itself is not.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/ahb_ext_ram.sv
// ============================================================================
// Module      : ahb_ext_ram
// Description : AHB-Lite external RAM slave with wait states, range errors and
//               write-to-read forwarding. EXTRAM_ERRINJ_EN adds ErrInject.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_ext_ram
   import ahb_ext_ram_pkg::*;
#(
   parameter int                 AHBW        = 64,
   parameter int                 PA_BITS     = 56,
   parameter logic [PA_BITS-1:0] BASE        = 'h8000_0000,
   parameter int                 DEPTH_WORDS = 4096,
   parameter int                 WAIT_STATES = 2
) (
   input  logic                HCLK,
   input  logic                HRESETn,
   input  logic                HSELEXT,
   input  logic [PA_BITS-1:0]  HADDR,
   input  logic [1:0]          HTRANS,
   input  logic                HWRITE,
   input  logic [2:0]          HSIZE,
   input  logic [AHBW-1:0]     HWDATA,
   input  logic [AHBW/8-1:0]   HWSTRB,
   input  logic                HREADY,
`ifdef EXTRAM_ERRINJ_EN
   input  logic                ErrInject,
`endif
   output logic [AHBW-1:0]     HRDATAEXT,
   output logic                HREADYEXT,
   output logic                HRESPEXT
);

   localparam int                 c_nb   = AHBW / 8;
   localparam int                 c_lb   = $clog2(c_nb);
   localparam int                 c_aw   = $clog2(DEPTH_WORDS);
   localparam logic [PA_BITS-1:0] c_span = PA_BITS'(DEPTH_WORDS * c_nb);
   localparam logic [3:0]         c_ws   = 4'(WAIT_STATES);

   extram_state_t      r_state;
   extram_state_t      w_state_nxt;
   logic [3:0]         r_cnt;
   logic [3:0]         w_cnt_nxt;
   logic [c_aw-1:0]    r_idx;
   logic               r_write;
   logic [AHBW-1:0]    r_fwd_mask;
   logic [AHBW-1:0]    r_fwd_data;

   logic               w_accept;
   logic               w_take;
   logic [PA_BITS-1:0] w_off;
   logic               w_range_err;
   logic               w_err;
   logic [c_aw-1:0]    w_idx;
   logic               w_commit;
   logic               w_rd_pipe;
   logic               w_rd_wait;
   logic               w_rd_load;
   logic [c_aw-1:0]    w_raddr;
   logic               w_fwd;
   logic [c_nb-1:0]    w_we;
   logic [AHBW-1:0]    w_strb_mask;
   logic [AHBW-1:0]    w_ram_q;
   logic               w_unused_hsize;

   assign w_unused_hsize = ^HSIZE;

   assign w_accept    = HSELEXT & htrans_active(HTRANS) & HREADY;
   assign w_off       = HADDR - BASE;
   assign w_range_err = (HADDR < BASE) | (w_off >= c_span);
   assign w_idx       = w_off[c_aw+c_lb-1:c_lb];

`ifdef EXTRAM_ERRINJ_EN
   assign w_err = w_range_err | ErrInject;
`else
   assign w_err = w_range_err;
`endif

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_take      = 1'b0;
      case (r_state)
         IDLE, LAST, ERR2: begin
            w_state_nxt = IDLE;
            if (w_accept) begin
               w_take = 1'b1;
               if (w_err) begin
                  w_state_nxt = ERR1;
               end else if (c_ws == 4'd0) begin
                  w_state_nxt = LAST;
               end else begin
                  w_state_nxt = WAIT;
                  w_cnt_nxt   = c_ws - 4'd1;
               end
            end
         end
         WAIT: begin
            if (r_cnt == 4'd0) begin
               w_state_nxt = LAST;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         ERR1:    w_state_nxt = ERR2;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      HREADYEXT = 1'b1;
      HRESPEXT  = 1'b0;
      case (r_state)
         WAIT: HREADYEXT = 1'b0;
         ERR1: begin
            HREADYEXT = 1'b0;
            HRESPEXT  = 1'b1;
         end
         ERR2:    HRESPEXT = 1'b1;
         default: ;
      endcase
   end

   // ----------------------------------------------------------- datapath
   // Error transfers latch r_write low, so they can never reach a commit.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_idx      <= '0;
         r_write    <= 1'b0;
         r_fwd_mask <= '0;
         r_fwd_data <= '0;
      end else begin
         if (w_take) begin
            r_idx   <= w_idx;
            r_write <= HWRITE & ~w_err;
         end
         if (w_rd_load) begin
            r_fwd_mask <= w_fwd ? w_strb_mask : '0;
            r_fwd_data <= HWDATA;
         end
      end
   end

   for (genvar b = 0; b < c_nb; b++) begin : g_lane
      assign w_strb_mask[8*b +: 8] = {8{HWSTRB[b]}};
   end

   assign w_commit  = (r_state == LAST) & r_write;
   assign w_we      = w_commit ? HWSTRB : '0;
   assign w_rd_pipe = w_take & ~w_err & ~HWRITE & (c_ws == 4'd0);
   assign w_rd_wait = (r_state == WAIT) & (r_cnt == 4'd0) & ~r_write;
   assign w_rd_load = w_rd_pipe | w_rd_wait;
   assign w_raddr   = w_rd_wait ? r_idx : w_idx;
   assign w_fwd     = w_commit & (w_raddr == r_idx);

   // The array reads old contents; committed lanes are overlaid here.
   assign HRDATAEXT = (w_ram_q & ~r_fwd_mask) | (r_fwd_data & r_fwd_mask);

   extram_array #(
      .WIDTH (AHBW),
      .DEPTH (DEPTH_WORDS)
   ) u_array (
      .clk     (HCLK),
      .rst_n   (HRESETn),
      .i_we    (w_we),
      .i_waddr (r_idx),
      .i_wdata (HWDATA),
      .i_re    (w_rd_load),
      .i_raddr (w_raddr),
      .o_rdata (w_ram_q)
   );

endmodule

`default_nettype wire

// File: tb/tb_ahb_ext_ram.sv
// ============================================================================
// Module      : tb_ahb_ext_ram
// Description : Self-checking bench for ahb_ext_ram (2 wait states and 0 wait states).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahb_ext_ram;

   localparam logic [55:0] c_base = 56'h8000_0000;

   typedef struct packed {
      int          ncyc;
      logic [15:0] rdy_tr;
      logic [15:0] resp_tr;
      logic [63:0] data;
      logic        chk;
   } obs_t;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        hsel_a, hsel_b, hold, ErrInject;
   logic [55:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [63:0] HWDATA;
   logic [7:0]  HWSTRB;
   logic [63:0] rdata_a, rdata_b;
   logic        rdy_a, rdy_b, resp_a, resp_b;
   logic        hready_a, hready_b;

   int   n_cmp = 0;
   int   n_err = 0;
   obs_t sb_q[$];
   obs_t obs_q[$];
   logic [63:0] model_a [int];
   logic [63:0] model_b [int];

   always #5 HCLK = ~HCLK;
   assign hready_a = rdy_a & ~hold;
   assign hready_b = rdy_b & ~hold;

   ahb_ext_ram #(.WAIT_STATES(2)) dut_a (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSELEXT(hsel_a), .HADDR(HADDR),
      .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
      .HWSTRB(HWSTRB), .HREADY(hready_a),
`ifdef EXTRAM_ERRINJ_EN
      .ErrInject(ErrInject),
`endif
      .HRDATAEXT(rdata_a), .HREADYEXT(rdy_a), .HRESPEXT(resp_a)
   );

   ahb_ext_ram #(.WAIT_STATES(0)) dut_b (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSELEXT(hsel_b), .HADDR(HADDR),
      .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
      .HWSTRB(HWSTRB), .HREADY(hready_b),
`ifdef EXTRAM_ERRINJ_EN
      .ErrInject(1'b0),
`endif
      .HRDATAEXT(rdata_b), .HREADYEXT(rdy_b), .HRESPEXT(resp_b)
   );

   // ------------------------------------------------------------ model
   function automatic logic [63:0] model_rd(input bit b, input int idx);
      if (b) return model_b.exists(idx) ? model_b[idx] : 64'h0;
      return model_a.exists(idx) ? model_a[idx] : 64'h0;
   endfunction

   function automatic void model_wr(input bit b, input int idx, input logic [63:0] wd,
                                    input logic [7:0] strb);
      logic [63:0] v;
      v = model_rd(b, idx);
      for (int i = 0; i < 8; i++) if (strb[i]) v[8*i +: 8] = wd[8*i +: 8];
      if (b) model_b[idx] = v; else model_a[idx] = v;
   endfunction

   function automatic obs_t exp_of(input int ws, input bit err, input bit chk,
                                   input logic [63:0] d);
      obs_t e;
      e         = '0;
      e.ncyc    = err ? 2 : ws + 1;
      e.rdy_tr  = 16'(1) << (e.ncyc - 1);
      e.resp_tr = err ? 16'h0003 : 16'h0000;
      e.data    = d;
      e.chk     = chk;
      return e;
   endfunction

   // ----------------------------------------------------------- driver
   // Entered and left at posedge+1.
   task automatic run_xfer(input bit b, input bit wr, input logic [55:0] addr,
                           input logic [63:0] wd, input logic [7:0] strb,
                           input bit inj, output obs_t o);
      o = '0;
      if (b) hsel_b = 1'b1; else hsel_a = 1'b1;
      HADDR = addr; HTRANS = 2'b10; HWRITE = wr; ErrInject = inj;
      @(posedge HCLK); #1;
      hsel_a = 1'b0; hsel_b = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; ErrInject = 1'b0;
      HWDATA = wd; HWSTRB = wr ? strb : 8'h00;
      for (int c = 0; c < 16; c++) begin
         @(negedge HCLK);
         o.rdy_tr[c]  = b ? rdy_b : rdy_a;
         o.resp_tr[c] = b ? resp_b : resp_a;
         o.ncyc       = c + 1;
         if (o.rdy_tr[c]) break;
         @(posedge HCLK); #1;
      end
      o.data = b ? rdata_b : rdata_a;
      @(posedge HCLK); #1;
      HWSTRB = 8'h00;
   endtask

   task automatic issue(input bit b, input bit wr, input logic [55:0] addr,
                        input logic [63:0] wd, input logic [7:0] strb,
                        input bit inj, input bit err);
      obs_t e, o;
      int   idx;
      idx = err ? 0 : int'((addr - c_base) >> 3);
      e = exp_of(b ? 0 : 2, err, !wr && !err, (wr || err) ? 64'h0 : model_rd(b, idx));
      sb_q.push_back(e);
      if (wr && !err) model_wr(b, idx, wd, strb);
      run_xfer(b, wr, addr, wd, strb, inj, o);
      obs_q.push_back(o);
   endtask

   // ------------------------------------------------------------ tests
   task automatic test_reset;
      HRESETn = 1'b0; hsel_a = 0; hsel_b = 0; hold = 0; ErrInject = 0;
      HADDR = '0; HTRANS = 2'b00; HWRITE = 0; HSIZE = 3'b011; HWDATA = '0; HWSTRB = '0;
      repeat (3) @(negedge HCLK);
      n_cmp += 3;
      if (rdy_a !== 1'b1)    begin n_err++; $display("FAIL reset_ready got=%b want=1", rdy_a); end
      if (resp_a !== 1'b0)   begin n_err++; $display("FAIL reset_resp got=%b want=0", resp_a); end
      if (rdata_a !== 64'h0) begin n_err++; $display("FAIL reset_rdata got=%h want=0", rdata_a); end
      n_cmp++;
      if ({rdy_b, resp_b, rdata_b} !== {1'b1, 1'b0, 64'h0}) begin
         n_err++; $display("FAIL reset_b got=%b%b %h want=10 0", rdy_b, resp_b, rdata_b);
      end
      HRESETn = 1'b1;
      @(posedge HCLK); #1;
   endtask

   task automatic drain_check(input string tag);
      obs_t e, o;
      while (sb_q.size() > 0 && obs_q.size() > 0) begin
         e = sb_q.pop_front(); o = obs_q.pop_front();
         n_cmp++;
         if ({o.ncyc, o.rdy_tr, o.resp_tr} !== {e.ncyc, e.rdy_tr, e.resp_tr}) begin
            n_err++;
            $display("FAIL %s_handshake got ncyc=%0d rdy=%h resp=%h want ncyc=%0d rdy=%h resp=%h",
                     tag, o.ncyc, o.rdy_tr, o.resp_tr, e.ncyc, e.rdy_tr, e.resp_tr);
         end
         if (e.chk) begin
            n_cmp++;
            if (o.data !== e.data) begin
               n_err++; $display("FAIL %s_rdata got=%h want=%h", tag, o.data, e.data);
            end
         end
      end
   endtask

   task automatic test_write_read;
      issue(0, 1, c_base + 8,  64'h1122334455667788, 8'hFF, 0, 0);
      issue(0, 0, c_base + 8,  64'h0, 8'h00, 0, 0);
      issue(0, 1, c_base + 24, 64'hFFEEDDCCBBAA9988, 8'hFF, 0, 0);
      issue(0, 1, c_base + 24, 64'h0123456789ABCDEF, 8'h81, 0, 0);
      issue(0, 0, c_base + 24, 64'h0, 8'h00, 0, 0);
      issue(1, 1, c_base + 40, 64'h0BADF00DDEADBEEF, 8'hFF, 0, 0);
      issue(1, 0, c_base + 40, 64'h0, 8'h00, 0, 0);
      drain_check("write_read");
   endtask

   task automatic test_back_to_back;
      logic [63:0] wd;
      obs_t        e;
      issue(1, 1, c_base,     64'h0102030405060708, 8'hFF, 0, 0);
      issue(1, 1, c_base + 8, 64'h5555555555555555, 8'hFF, 0, 0);
      drain_check("b2b_setup");
      for (int k = 0; k < 2; k++) begin
         wd = (k == 0) ? 64'hAAAAAAAAAAAAAAAA : 64'hCCCCCCCCCCCCCCCC;
         hsel_b = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1;
         HADDR = (k == 0) ? c_base : c_base + 8;
         @(posedge HCLK); #1;
         HADDR = c_base; HWRITE = 1'b0; HWDATA = wd; HWSTRB = 8'h0F;
         @(negedge HCLK);
         n_cmp++;
         if (rdy_b !== 1'b1) begin n_err++; $display("FAIL b2b_write_ready k=%0d got=%b want=1", k, rdy_b); end
         @(posedge HCLK); #1;
         hsel_b = 1'b0; HTRANS = 2'b00; HWSTRB = 8'h00;
         model_wr(1, k, wd, 8'h0F);
         sb_q.push_back(exp_of(0, 0, 1, model_rd(1, 0)));
         @(negedge HCLK);
         e = sb_q.pop_front();
         n_cmp++;
         if ({rdy_b, resp_b, rdata_b} !== {1'b1, 1'b0, e.data}) begin
            n_err++;
            $display("FAIL b2b_read k=%0d got=%b%b %h want=10 %h", k, rdy_b, resp_b, rdata_b, e.data);
         end
         @(posedge HCLK); #1;
      end
      issue(1, 0, c_base,     64'h0, 8'h00, 0, 0);
      issue(1, 0, c_base + 8, 64'h0, 8'h00, 0, 0);
      drain_check("b2b_commit");
   endtask

   task automatic test_range_error;
      issue(0, 1, c_base,          64'h0F0E0D0C0B0A0908, 8'hFF, 0, 0);
      issue(0, 0, c_base + 32768,  64'h0, 8'h00, 0, 1);
      issue(0, 1, c_base + 32768,  64'hBADBADBADBADBAD0, 8'hFF, 0, 1);
      issue(0, 1, c_base - 8,      64'hBADBADBADBADBAD1, 8'hFF, 0, 1);
      issue(1, 1, c_base + 32768,  64'hBADBADBADBADBAD2, 8'hFF, 0, 1);
      issue(0, 0, c_base,          64'h0, 8'h00, 0, 0);
      issue(1, 0, c_base,          64'h0, 8'h00, 0, 0);
      drain_check("range_err");
   endtask

   task automatic test_no_accept;
      hsel_a = 1'b1; HTRANS = 2'b01; HWRITE = 1'b1; HADDR = c_base + 8;
      HWDATA = 64'hDEADDEADDEADDEAD; HWSTRB = 8'hFF;
      @(posedge HCLK); #1;
      HTRANS = 2'b10; hold = 1'b1;
      @(posedge HCLK); #1;
      hsel_a = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; hold = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge HCLK);
         n_cmp++;
         if ({rdy_a, resp_a} !== 2'b10) begin
            n_err++; $display("FAIL no_accept_idle c=%0d got=%b%b want=10", c, rdy_a, resp_a);
         end
         @(posedge HCLK); #1;
      end
      HWSTRB = 8'h00;
      issue(0, 0, c_base + 8, 64'h0, 8'h00, 0, 0);
      drain_check("no_accept");
   endtask

   task automatic test_reset_midxfer;
      issue(0, 1, c_base + 16, 64'hCAFEF00D12345678, 8'hFF, 0, 0);
      issue(0, 0, c_base + 16, 64'h0, 8'h00, 0, 0);
      drain_check("rst_setup");
      hsel_a = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = c_base + 16;
      @(posedge HCLK); #1;
      hsel_a = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
      HWDATA = 64'hDEADBEEFDEADBEEF; HWSTRB = 8'hFF;
      @(negedge HCLK);
      n_cmp++;
      if (rdy_a !== 1'b0) begin n_err++; $display("FAIL rst_in_wait got=%b want=0", rdy_a); end
      #2 HRESETn = 1'b0;
      #1;
      n_cmp++;
      if ({rdy_a, resp_a, rdata_a} !== {1'b1, 1'b0, 64'h0}) begin
         n_err++; $display("FAIL rst_async got=%b%b %h want=10 0", rdy_a, resp_a, rdata_a);
      end
      @(negedge HCLK); HRESETn = 1'b1;
      @(posedge HCLK); #1;
      HWSTRB = 8'h00;
      issue(0, 0, c_base + 16, 64'h0, 8'h00, 0, 0);
      drain_check("rst_dropped");
   endtask

`ifdef EXTRAM_ERRINJ_EN
   task automatic test_err_inject;
      issue(0, 1, c_base + 8, 64'h7777777777777777, 8'hFF, 1, 1);
      issue(0, 0, c_base + 8, 64'h0, 8'h00, 0, 0);
      drain_check("err_inject");
   endtask
`endif

   initial begin
      test_reset;
      test_write_read;
      test_back_to_back;
      test_range_error;
      test_no_accept;
      test_reset_midxfer;
`ifdef EXTRAM_ERRINJ_EN
      test_err_inject;
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout compared=%0d", n_cmp);
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
